// File: rtl/rcom_pkg.sv
// rcom_pkg: shared types and constants for the remote-command transmitter.
//   rcom_state_t     - sequencer states (IDLE, TX_HIGH, TX_LOW)
//   FRAME_BITS       - bits per 8N1 frame (start + 8 data + stop)
//   DEFAULT_BAUD_DIV - clock cycles per bit at 50 MHz / 19200 baud
package rcom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX_HIGH,
    TX_LOW
  } rcom_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single 8N1 frame serializer with zero-gap chaining.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   trmt     - start a frame; honoured when idle or in the tx_done cycle
//   tx_data  - byte to send, LSB first; read live at each bit boundary, so
//              the driver holds it stable for the whole frame
//   TX       - registered serial output, idles high
//   tx_done  - one-cycle pulse in the last cycle of the stop bit
// The start bit appears on TX on the same edge that samples trmt, and each
// bit lasts exactly BAUD_DIV cycles.
module uart_tx_byte
  import rcom_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  logic          running;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic          bit_end;

  assign bit_end = running && (baud_cnt == BAUD_LAST);
  assign tx_done = bit_end && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      TX       <= 1'b1;
    end else if (trmt && (!running || tx_done)) begin
      // New frame: drive the start bit immediately. Taking this branch in
      // the tx_done cycle gives back-to-back frames with no idle gap.
      running  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      TX       <= 1'b0;
    end else if (running) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          running <= 1'b0;
          bit_cnt <= '0;
          TX      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          // Entering bit k+1: data bit k for k=0..7, stop bit after that.
          TX      <= (bit_cnt == LAST_BIT - 4'd1) ? 1'b1 : tx_data[bit_cnt[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcom_tx.sv
// rcom_tx: sends a 16-bit command as two 8N1 frames, high byte first.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   cmd      - command word, captured into a shadow register on acceptance
//   snd_cmd  - send request
//   TX       - serial line, idles high, registered
//   busy     - high while a command is being transmitted
//   cmd_snt  - sticky done flag, set at completion, cleared on next accept
// Handshake: snd_cmd acts as valid and !busy as ready; a send is accepted on
// any edge where snd_cmd=1 and busy=0. Requests while busy are dropped, not
// queued. busy rises on the acceptance edge and falls on the completion edge.
module rcom_tx
  import rcom_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt
);

  rcom_state_t state_q, state_d;
  logic [15:0] shadow;
  logic        accept;
  logic        finish;
  logic        trmt;
  logic        tx_done;
  logic [7:0]  tx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shadow  <= '0;
      cmd_snt <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shadow  <= cmd;
        cmd_snt <= 1'b0;
      end else if (finish) begin
        cmd_snt <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    trmt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          accept  = 1'b1;
          trmt    = 1'b1;
          state_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        // Chain the low-byte frame in the stop-bit end cycle: zero gap.
        if (tx_done) begin
          trmt    = 1'b1;
          state_d = TX_LOW;
        end
      end
      TX_LOW: begin
        if (tx_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The serializer only reads data after the start bit, by which time the
  // shadow holds the accepted word, so the byte select keys off the state.
  assign tx_data = (state_q == TX_LOW) ? shadow[7:0] : shadow[15:8];
  assign busy    = (state_q != IDLE);

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done)
  );

endmodule

// File: tb/tb_rcom_tx.sv
module tb_rcom_tx;

  localparam int BD = 16;

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        TX;
  logic        busy;
  logic        cmd_snt;

  int n_cmp;
  int n_bad;

  rcom_tx #(.BAUD_DIV(BD)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd),
    .snd_cmd(snd_cmd),
    .TX     (TX),
    .busy   (busy),
    .cmd_snt(cmd_snt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a command and return 1 ns after the acceptance edge A.
  task automatic accept_cmd(input logic [15:0] c, input logic hold);
    @(negedge clk);
    cmd     = c;
    snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) snd_cmd = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_snt", cmd_snt, 0);
  endtask

  // Called at A+1ns. Samples every cycle of both frames against the word at
  // the head of the expected queue, then checks the completion edge.
  task automatic rx_word(input string tag);
    logic [15:0] exp_w;
    logic [7:0]  eb;
    logic [9:0]  fb;
    logic [15:0] samp;
    logic [9:0]  mid;
    logic [15:0] got_w;
    logic        snt_early;
    exp_w     = exp_q.pop_front();
    got_w     = '0;
    snt_early = 1'b0;
    for (int f = 0; f < 2; f++) begin
      eb = (f == 0) ? exp_w[15:8] : exp_w[7:0];
      fb = {1'b1, eb, 1'b0};
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < BD; c++) begin
          samp[c] = TX;
          if (c == BD / 2) mid[b] = TX;
          if (cmd_snt !== 1'b0 || busy !== 1'b1) snt_early = 1'b1;
          @(posedge clk);
          #1;
        end
        check($sformatf("%s_f%0d_bit%0d", tag, f, b), samp, {16{fb[b]}});
      end
      if (f == 0) got_w[15:8] = mid[8:1];
      else        got_w[7:0]  = mid[8:1];
    end
    check({tag, "_word"}, got_w, exp_w);
    check({tag, "_snt_early"}, snt_early, 0);
    check({tag, "_done_snt"}, cmd_snt, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_tx"}, TX, 1);
  endtask

  // Idle window: line high, not busy, flag steady.
  task automatic idle_window(input string tag, input int n, input logic exp_snt);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (TX !== 1'b1 || busy !== 1'b0 || cmd_snt !== exp_snt) bad++;
      @(posedge clk);
      #1;
    end
    check({tag, "_idle_bad_cycles"}, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    cmd     = '0;
    snd_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_snt", cmd_snt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_window("post_rst", 5, 1'b0);

    // 1: nominal send
    exp_q.push_back(16'h2A5F);
    accept_cmd(16'h2A5F, 1'b0);
    rx_word("nominal");
    idle_window("nominal", 20, 1'b1);

    // 2: request while busy is dropped
    exp_q.push_back(16'h0000);
    accept_cmd(16'h0000, 1'b0);
    fork
      rx_word("busy_sup");
      begin
        repeat (99) @(posedge clk);
        #2;
        cmd     = 16'hFFFF;
        snd_cmd = 1'b1;
        @(posedge clk);
        #2;
        snd_cmd = 1'b0;
      end
    join
    idle_window("busy_sup", 400, 1'b1);

    // 3: cmd changes after acceptance
    exp_q.push_back(16'h1234);
    accept_cmd(16'h1234, 1'b0);
    fork
      rx_word("shadow");
      begin
        repeat (5) @(posedge clk);
        #2;
        cmd = 16'hABCD;
      end
    join
    idle_window("shadow", 10, 1'b1);

    // 4: reset mid-frame
    accept_cmd(16'hA5A5, 1'b0);
    repeat (149) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", TX, 1);
    check("midrst_busy", busy, 0);
    check("midrst_snt", cmd_snt, 0);
    rst = 1'b0;
    idle_window("midrst", 40, 1'b0);
    exp_q.push_back(16'h00FF);
    accept_cmd(16'h00FF, 1'b0);
    rx_word("after_rst");

    // 5: snd_cmd held high, restart the cycle after completion
    exp_q.push_back(16'hC3C3);
    exp_q.push_back(16'hC3C3);
    accept_cmd(16'hC3C3, 1'b1);
    rx_word("b2b_first");
    @(posedge clk);
    #1;
    check("b2b_restart_tx", TX, 0);
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_snt", cmd_snt, 0);
    rx_word("b2b_second");
    snd_cmd = 1'b0;
    idle_window("b2b", 40, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
